riscv_decode_stage: RTL
=======================

# riscv_decode_stage

Registered RV32I decode stage with a valid/ready handshake and a two-entry skid buffer. Sits between the fetch stage and register-file read, and generalises plain field extraction: it classifies each instruction by format and builds the full sign-extended immediate for I/S/B/U/J at a parametrised width. It also flags illegal encodings and derives the register-write enable. Fetch and execute can stall independently without losing or reordering instructions.

## Interface
- XLEN, 32, immediate and PC width; legal values 32 or 64; immediates sign-extend to XLEN.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all buffered instructions.
- in_valid  in  1  fetch offers inst/pc.
- in_ready  out  1  stage can accept this cycle.
- inst  in  32  instruction word.
- pc  in  XLEN  address of inst.
- out_valid  out  1  decoded entry at head.
- out_ready  in  1  consumer takes head entry.
- out_pc  out  XLEN  pc of head entry.
- opcode  out  7  inst[6:0].
- rd  out  5  inst[11:7].
- funct3  out  3  inst[14:12].
- rs1  out  5  inst[19:15].
- rs2  out  5  inst[24:20].
- funct7  out  7  inst[31:25].
- fmt  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
- imm  out  XLEN  sign-extended immediate; 0 for R and illegal.
- rd_we  out  1  instruction writes rd, and rd != 0.
- illegal  out  1  unsupported encoding.

## Operation
- Decode is combinational on inst. The result (fields, fmt, imm, rd_we, illegal, pc) is written into the buffer on accept. All outputs come straight from the head-entry registers.
- Format by opcode:
  - 0110011 → R.
  - 0010011, 0000011, 1100111, 1110011, 0001111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Any other opcode, or inst[1:0] != 2'b11 → fmt=7, illegal=1, imm=0, rd_we=0.
- Immediates, sign bit inst[31] replicated to XLEN:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}, then sign-extended.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- rd_we = 1 for R, I, U and J when rd != 0; 0 for S, B and illegal.
- Raw fields (opcode through funct7) are always passed through unmodified, including for illegal instructions.
- Buffer: two entries, FIFO order, occupancy count 0..2.
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count != 2), driven from registered state only; no combinational path from out_ready.
  - out_valid = (count != 0).
- Count update:
  - accept only: count+1.
  - pop only: count−1.
  - both: count unchanged; the new entry lands behind the surviving one, or at head if count was 1.
- flush: count → 0 at the next edge. Any accept in the same cycle is discarded. flush beats accept and pop.
- rst: same as flush. Also clears all data registers to 0.

## Timing
- Latency: an instruction accepted at edge N is presented with out_valid=1 after edge N.
- Throughput: one instruction per cycle while out_ready=1.
- Values after reset:
  - out_valid=0, in_ready=1.
  - fmt=0, imm=0, rd_we=0, illegal=0, out_pc=0, all fields 0.
- Head outputs stay stable while out_valid=1 and out_ready=0.
- Full (count=2): in_ready=0, and in_valid is ignored.
- Empty: out_ready is ignored.
- Reset or flush mid-stall: buffer empties in one cycle. in_ready=1 on the following cycle.
- PC is passed through untouched; no wrap or arithmetic.

## Test plan
- Accept 0xFFF10093 (addi x1,x2,−1), XLEN=32 → next cycle fmt=1, rd=1, rs1=2, imm=0xFFFFFFFF, rd_we=1, illegal=0. Same input with XLEN=64 → imm=0xFFFFFFFFFFFFFFFF.
- Stream back-to-back with out_ready=1:
  - 0x00512423 (sw) → fmt=2, rs1=2, rs2=5, imm=8, rd_we=0.
  - 0xFE000EE3 (beq) → fmt=3, imm=0xFFFFFFFC.
  - 0x123451B7 (lui x3) → fmt=4, rd=3, imm=0x12345000.
  - 0x001000EF (jal x1) → fmt=5, imm=0x800, rd_we=1.
  - Required: one result per cycle.
- 0x00000000 and 0x0000007F → illegal=1, fmt=7, imm=0, rd_we=0. 0x00000013 (addi x0) → rd_we=0.
- out_ready=0 while three valid instructions A, B, C are offered → in_ready drops after A and B are accepted; C is held by fetch. Raise out_ready → A, B, C emerge in order with matching out_pc; none is lost.
- Buffer full, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, and the offered instruction never appears. Repeat with rst.
- Count=1 with simultaneous accept and pop for 10 cycles → count stays 1, outputs lag inputs by exactly one cycle.

Source files
------------

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: combinational field/immediate decode feeding a two-entry
// skid buffer. All outputs come from the head-entry registers.
module riscv_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            rd_we,
  output logic            illegal
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            rd_we;
    logic            illegal;
  } entry_t;

  entry_t     dec;
  entry_t     slot0_q, slot0_d;
  entry_t     slot1_q, slot1_d;
  logic [1:0] count_q, count_d;
  logic       accept;
  logic       pop;

  always_comb begin
    dec      = '0;
    dec.inst = inst;
    dec.pc   = pc;
    if (inst[1:0] != 2'b11) begin
      dec.fmt = FMT_ILL;
    end else begin
      case (inst[6:0])
        7'b0110011:                                                 dec.fmt = FMT_R;
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: dec.fmt = FMT_I;
        7'b0100011:                                                 dec.fmt = FMT_S;
        7'b1100011:                                                 dec.fmt = FMT_B;
        7'b0110111, 7'b0010111:                                     dec.fmt = FMT_U;
        7'b1101111:                                                 dec.fmt = FMT_J;
        default:                                                    dec.fmt = FMT_ILL;
      endcase
    end
    // Fill with the sign bit first, then overlay the format-specific low bits.
    dec.imm = {XLEN{inst[31]}};
    case (dec.fmt)
      FMT_I:   dec.imm[11:0] = inst[31:20];
      FMT_S:   dec.imm[11:0] = {inst[31:25], inst[11:7]};
      FMT_B:   dec.imm[12:0] = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   dec.imm[31:0] = {inst[31:12], 12'b0};
      FMT_J:   dec.imm[20:0] = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: dec.imm       = '0;
    endcase
    dec.illegal = (dec.fmt == FMT_ILL);
    dec.rd_we   = ((dec.fmt == FMT_R) || (dec.fmt == FMT_I) ||
                   (dec.fmt == FMT_U) || (dec.fmt == FMT_J)) && (inst[11:7] != 5'd0);
  end

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Slot 0 is always the head; a pop shifts slot 1 forward.
  always_comb begin
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({accept, pop})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = dec;
          else                 slot1_d = dec;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          slot0_d = (count_q == 2'd1) ? dec : slot1_q;
          slot1_d = dec;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign out_pc  = slot0_q.pc;
  assign opcode  = slot0_q.inst[6:0];
  assign rd      = slot0_q.inst[11:7];
  assign funct3  = slot0_q.inst[14:12];
  assign rs1     = slot0_q.inst[19:15];
  assign rs2     = slot0_q.inst[24:20];
  assign funct7  = slot0_q.inst[31:25];
  assign fmt     = slot0_q.fmt;
  assign imm     = slot0_q.imm;
  assign rd_we   = slot0_q.rd_we;
  assign illegal = slot0_q.illegal;

endmodule
